trap_ctrl: RTL



---
 rtl/trap_pkg.sv | 34 +++
 rtl/trap_mstatus_upd.sv | 29 ++
 rtl/trap_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - trap sequencer states, CSR addresses and mstatus/privilege constants.
// TRAP_MTVAL_EN adds the mtval write state and its CSR address.
package trap_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_E_MEPC    = 3'd1,
        S_E_MCAUSE  = 3'd2,
`ifdef TRAP_MTVAL_EN
        S_E_MTVAL   = 3'd3,
`endif
        S_E_MSTATUS = 3'd4,
        S_E_REDIR   = 3'd5,
        S_X_MSTATUS = 3'd6,
        S_X_REDIR   = 3'd7
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
`ifdef TRAP_MTVAL_EN
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
`endif

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/trap_mstatus_upd.sv
// rtl/trap_mstatus_upd.sv - mstatus interrupt-stack update for trap entry (push) and mret (pop).
module trap_mstatus_upd
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [1:0]      priv_lvl,
    input  logic            is_entry,
    output logic [XLEN-1:0] mstatus_out,
    output logic [1:0]      mpp_out
);

    always_comb begin
        mstatus_out = mstatus_in;
        if (is_entry) begin
            mstatus_out[MSTATUS_MPIE]                  = mstatus_in[MSTATUS_MIE];
            mstatus_out[MSTATUS_MIE]                   = 1'b0;
            mstatus_out[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_lvl;
        end else begin
            mstatus_out[MSTATUS_MIE]                   = mstatus_in[MSTATUS_MPIE];
            mstatus_out[MSTATUS_MPIE]                  = 1'b1;
            mstatus_out[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        end
    end

    assign mpp_out = mstatus_in[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry/exit sequencer owning the CSR write port.
// TRAP_MTVAL_EN adds the mtval write step (entry latency 5 instead of 4).
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_en,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_val,
    input  logic            mret,
    input  logic [XLEN-1:0] pc_addr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_raddr,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            trap_taken,
    output logic            trap_done,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic [1:0]      priv_lvl
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_priv;
    logic [1:0]      r_mpp;
    logic [XLEN-1:0] r_epc;
    logic [3:0]      r_cause;
    logic [XLEN-1:0] w_mstatus_new;
    logic [1:0]      w_mpp;
    logic            w_is_entry;

`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0] r_tval;
`else
    logic            w_unused_tval;
    assign w_unused_tval = ^exc_val;
`endif

    assign w_is_entry = (r_state == S_E_MSTATUS);
    assign priv_lvl   = r_priv;

    trap_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
        .mstatus_in  (csr_rdata),
        .priv_lvl    (r_priv),
        .is_entry    (w_is_entry),
        .mstatus_out (w_mstatus_new),
        .mpp_out     (w_mpp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_priv  <= RESET_PRIV;
            r_mpp   <= '0;
            r_epc   <= '0;
            r_cause <= '0;
`ifdef TRAP_MTVAL_EN
            r_tval  <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && exc_en) begin
                r_epc   <= pc_addr;
                r_cause <= exc_code;
`ifdef TRAP_MTVAL_EN
                r_tval  <= exc_val;
`endif
            end
            // MPP is read while mstatus is being rewritten; keep it for the redirect cycle.
            if (r_state == S_X_MSTATUS) begin
                r_mpp <= w_mpp;
            end
            if (r_state == S_E_REDIR) begin
                r_priv <= PRIV_M;
            end else if (r_state == S_X_REDIR) begin
                r_priv <= r_mpp;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        csr_raddr   = '0;
        csr_we      = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        trap_taken  = 1'b0;
        trap_done   = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        case (r_state)
            S_IDLE: begin
                if (exc_en) begin
                    w_next = S_E_MEPC;
                end else if (mret) begin
                    w_next = S_X_MSTATUS;
                end
            end
            S_E_MEPC: begin
                trap_taken = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MEPC;
                csr_wdata  = r_epc & ALIGN_MASK;
                w_next     = S_E_MCAUSE;
            end
            S_E_MCAUSE: begin
                trap_taken = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MCAUSE;
                csr_wdata  = {{(XLEN-4){1'b0}}, r_cause};
`ifdef TRAP_MTVAL_EN
                w_next     = S_E_MTVAL;
`else
                w_next     = S_E_MSTATUS;
`endif
            end
`ifdef TRAP_MTVAL_EN
            S_E_MTVAL: begin
                trap_taken = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MTVAL;
                csr_wdata  = r_tval;
                w_next     = S_E_MSTATUS;
            end
`endif
            S_E_MSTATUS: begin
                trap_taken = 1'b1;
                csr_raddr  = CSR_MSTATUS;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MSTATUS;
                csr_wdata  = w_mstatus_new;
                w_next     = S_E_REDIR;
            end
            S_E_REDIR: begin
                trap_taken  = 1'b1;
                csr_raddr   = CSR_MTVEC;
                pc_redirect = 1'b1;
                pc_target   = csr_rdata & ALIGN_MASK;
                w_next      = S_IDLE;
            end
            S_X_MSTATUS: begin
                trap_done = 1'b1;
                csr_raddr = CSR_MSTATUS;
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = w_mstatus_new;
                w_next    = S_X_REDIR;
            end
            S_X_REDIR: begin
                trap_done   = 1'b1;
                csr_raddr   = CSR_MEPC;
                pc_redirect = 1'b1;
                pc_target   = csr_rdata & ALIGN_MASK;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
